// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing the cache<->Mem line bus between two cache requesters.
// Runs the whole line transaction (command, write beats, response wait, read beats) and aborts on a silent Mem.
module mem_bus_arbiter #(
    parameter int ADDR2_BUS_SIZE  = 14,
    parameter int DATA_BUS_SIZE   = 16,
    parameter int CACHE_LINE_SIZE = 16,
    parameter int MEM_TIMEOUT     = 100
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [1:0]                REQ_CMD0,
    input  logic [1:0]                REQ_CMD1,
    input  logic [ADDR2_BUS_SIZE-1:0] REQ_ADDR0,
    input  logic [ADDR2_BUS_SIZE-1:0] REQ_ADDR1,
    input  logic [DATA_BUS_SIZE-1:0]  REQ_WDATA0,
    input  logic [DATA_BUS_SIZE-1:0]  REQ_WDATA1,
    output logic                      GNT0,
    output logic                      GNT1,
    output logic                      RSP_VALID0,
    output logic                      RSP_VALID1,
    output logic [DATA_BUS_SIZE-1:0]  RSP_DATA,
    output logic                      DONE0,
    output logic                      DONE1,
    output logic                      ERR,
    output logic [1:0]                MEM_CMD,
    output logic [ADDR2_BUS_SIZE-1:0] MEM_ADDR,
    output logic [DATA_BUS_SIZE-1:0]  MEM_WDATA,
    input  logic                      MEM_RSP,
    input  logic [DATA_BUS_SIZE-1:0]  MEM_RDATA
);
    localparam int BEATS = CACHE_LINE_SIZE / 2;
    localparam int BW    = (BEATS > 2) ? $clog2(BEATS) : 1;
    localparam int TW    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(MEM_TIMEOUT - 1);
    localparam logic [1:0] C2_NOP        = 2'd0;
    localparam logic [1:0] C2_WRITE_LINE = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_GRANT, S_ISSUE, S_WR_DATA, S_WAIT_RSP, S_RD_DATA, S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic                      ptr_q, ptr_d;
    logic                      id_q, id_d;
    logic                      err_q, err_d;
    logic [BW-1:0]             beat_q, beat_d;
    logic [TW-1:0]             tmo_q, tmo_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [DATA_BUS_SIZE-1:0]  rsp_data_q, rsp_data_d;
    logic [1:0]                cmd_q, cmd_d;
    logic [ADDR2_BUS_SIZE-1:0] addr_q, addr_d;
    logic                      req0, req1, win;
    logic [DATA_BUS_SIZE-1:0]  wdata_sel;

    // Both C2_READ_LINE (2) and C2_WRITE_LINE (3) have bit 1 set; 0/1 are not requests.
    assign req0      = REQ_CMD0[1];
    assign req1      = REQ_CMD1[1];
    assign wdata_sel = id_q ? REQ_WDATA1 : REQ_WDATA0;

    assign RSP_VALID0 = rsp_valid_q & ~id_q;
    assign RSP_VALID1 = rsp_valid_q & id_q;
    assign RSP_DATA   = rsp_data_q;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        err_d       = err_q;
        beat_d      = beat_q;
        tmo_d       = tmo_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = '0;
        win         = 1'b0;
        GNT0        = 1'b0;
        GNT1        = 1'b0;
        DONE0       = 1'b0;
        DONE1       = 1'b0;
        ERR         = 1'b0;
        MEM_CMD     = C2_NOP;
        MEM_ADDR    = '0;
        MEM_WDATA   = '0;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    if (req0 && req1) begin
                        win   = ptr_q;
                        ptr_d = ~ptr_q;
                    end else begin
                        win = req1;
                    end
                    id_d    = win;
                    cmd_d   = win ? REQ_CMD1 : REQ_CMD0;
                    addr_d  = win ? REQ_ADDR1 : REQ_ADDR0;
                    err_d   = 1'b0;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                GNT0    = ~id_q;
                GNT1    = id_q;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                MEM_CMD  = cmd_q;
                MEM_ADDR = addr_q;
                tmo_d    = '0;
                if (cmd_q == C2_WRITE_LINE) begin
                    MEM_WDATA = wdata_sel;
                    beat_d    = BW'(1);
                    state_d   = S_WR_DATA;
                end else begin
                    state_d = S_WAIT_RSP;
                end
            end
            S_WR_DATA: begin
                MEM_WDATA = wdata_sel;
                if (beat_q == LAST_BEAT) state_d = S_WAIT_RSP;
                else                     beat_d  = beat_q + BW'(1);
            end
            S_WAIT_RSP: begin
                tmo_d = tmo_q + TW'(1);
                // A response in the expiry cycle still counts as success.
                if (MEM_RSP) begin
                    if (cmd_q == C2_WRITE_LINE) begin
                        state_d = S_DONE;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = MEM_RDATA;
                        beat_d      = BW'(1);
                        state_d     = S_RD_DATA;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_RD_DATA: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = MEM_RDATA;
                if (beat_q == LAST_BEAT) state_d = S_DONE;
                else                     beat_d  = beat_q + BW'(1);
            end
            S_DONE: begin
                DONE0   = ~id_q;
                DONE1   = id_q;
                ERR     = err_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= S_IDLE;
            ptr_q       <= 1'b0;
            id_q        <= 1'b0;
            err_q       <= 1'b0;
            beat_q      <= '0;
            tmo_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            err_q       <= err_d;
            beat_q      <= beat_d;
            tmo_q       <= tmo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Latched command/address only reach the bus through the state decode, so they need no reset.
    always_ff @(posedge CLK) begin
        cmd_q  <= cmd_d;
        addr_q <= addr_d;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scenario bench for mem_bus_arbiter: read beats are scoreboarded on RSP_VALIDk, write beats on MEM_WDATA.
module tb_mem_bus_arbiter;
    localparam int AW    = 14;
    localparam int DW    = 16;
    localparam int BEATS = 8;
    localparam int TMO   = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req_cmd0, req_cmd1;
    logic [AW-1:0] req_addr0, req_addr1;
    logic [DW-1:0] req_wdata0, req_wdata1;
    logic          gnt0, gnt1, rsp_valid0, rsp_valid1, done0, done1, err;
    logic [DW-1:0] rsp_data;
    logic [1:0]    mem_cmd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rsp;
    logic [DW-1:0] mem_rdata;
    logic [54:0]   all_out;

    int n_cmp = 0;
    int n_bad = 0;
    logic [16:0] rd_q[$];
    logic [15:0] wr_q[$];
    int          gnt_q[$];
    logic [16:0] mon_exp;

    always #5 clk = ~clk;

    assign all_out = {gnt0, gnt1, rsp_valid0, rsp_valid1, done0, done1, err,
                      mem_cmd, mem_addr, mem_wdata, rsp_data};

    mem_bus_arbiter #(
        .ADDR2_BUS_SIZE(AW), .DATA_BUS_SIZE(DW), .CACHE_LINE_SIZE(16), .MEM_TIMEOUT(TMO)
    ) dut (
        .CLK(clk), .RESET(rst_n),
        .REQ_CMD0(req_cmd0), .REQ_CMD1(req_cmd1),
        .REQ_ADDR0(req_addr0), .REQ_ADDR1(req_addr1),
        .REQ_WDATA0(req_wdata0), .REQ_WDATA1(req_wdata1),
        .GNT0(gnt0), .GNT1(gnt1),
        .RSP_VALID0(rsp_valid0), .RSP_VALID1(rsp_valid1), .RSP_DATA(rsp_data),
        .DONE0(done0), .DONE1(done1), .ERR(err),
        .MEM_CMD(mem_cmd), .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata),
        .MEM_RSP(mem_rsp), .MEM_RDATA(mem_rdata)
    );

    // Read-beat scoreboard: every forwarded beat must match the oldest expected {id, data}.
    always @(negedge clk) begin
        if (rsp_valid0 || rsp_valid1) begin
            n_cmp++;
            if (rd_q.size() == 0) begin
                n_bad++;
                $display("FAIL rsp_beat: got id%0d data %h, required no beat", rsp_valid1, rsp_data);
            end else begin
                mon_exp = rd_q.pop_front();
                if ((rsp_valid0 && rsp_valid1) || {rsp_valid1, rsp_data} !== mon_exp) begin
                    n_bad++;
                    $display("FAIL rsp_beat: got v0=%0d v1=%0d data %h, required id%0d data %h",
                             rsp_valid0, rsp_valid1, rsp_data, mon_exp[16], mon_exp[15:0]);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_cmd0 = 2'd0; req_cmd1 = 2'd0;
        req_addr0 = '0;  req_addr1 = '0;
        req_wdata0 = '0; req_wdata1 = '0;
        mem_rsp = 1'b0;  mem_rdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        req_cmd0 = 2'd2;
        mem_rsp = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (all_out !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs: got %h, required 0", all_out);
            end
            next_cycle();
        end
        idle_inputs();
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_read();
        for (int c = 0; c <= 16; c++) begin
            req_cmd0  = (c <= 1) ? 2'd2 : 2'd0;
            req_addr0 = 14'h0A5;
            mem_rsp   = (c == 6);
            if (c >= 6 && c <= 13) begin
                mem_rdata = 16'h1100 + 16'(c - 6);
                rd_q.push_back({1'b0, mem_rdata});
            end else begin
                mem_rdata = '0;
            end
            @(negedge clk);
            n_cmp++;
            if (gnt0 !== (c == 1) || gnt1 !== 1'b0) begin
                n_bad++; $display("FAIL read_gnt c%0d: got %0d%0d, required %0d0", c, gnt0, gnt1, c == 1);
            end
            n_cmp++;
            if (mem_cmd !== ((c == 2) ? 2'd2 : 2'd0)) begin
                n_bad++; $display("FAIL read_cmd c%0d: got %0d", c, mem_cmd);
            end
            if (c == 2) begin
                n_cmp++;
                if (mem_addr !== 14'h0A5) begin
                    n_bad++; $display("FAIL read_addr: got %h, required 0a5", mem_addr);
                end
            end
            n_cmp++;
            if (rsp_valid0 !== (c >= 7 && c <= 14)) begin
                n_bad++; $display("FAIL read_valid c%0d: got %0d", c, rsp_valid0);
            end
            n_cmp++;
            if (done0 !== (c == 14) || done1 !== 1'b0 || err !== 1'b0) begin
                n_bad++; $display("FAIL read_done c%0d: got done0=%0d done1=%0d err=%0d", c, done0, done1, err);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_write();
        logic [15:0] w;
        for (int c = 0; c <= 15; c++) begin
            req_cmd1  = (c <= 1) ? 2'd3 : 2'd0;
            req_addr1 = 14'h3FF;
            if (c >= 2 && c <= 9) begin
                req_wdata1 = 16'hB000 + 16'(c - 2);
                wr_q.push_back(req_wdata1);
            end else begin
                req_wdata1 = 16'hDEAD;
            end
            req_wdata0 = 16'h5555;
            mem_rsp    = (c == 5) || (c == 12);
            @(negedge clk);
            n_cmp++;
            if (gnt1 !== (c == 1) || gnt0 !== 1'b0) begin
                n_bad++; $display("FAIL write_gnt c%0d: got %0d%0d", c, gnt0, gnt1);
            end
            n_cmp++;
            if (mem_cmd !== ((c == 2) ? 2'd3 : 2'd0)) begin
                n_bad++; $display("FAIL write_cmd c%0d: got %0d", c, mem_cmd);
            end
            if (c == 2) begin
                n_cmp++;
                if (mem_addr !== 14'h3FF) begin
                    n_bad++; $display("FAIL write_addr: got %h, required 3ff", mem_addr);
                end
            end
            n_cmp++;
            w = (c >= 2 && c <= 9 && wr_q.size() != 0) ? wr_q.pop_front() : 16'h0000;
            if (mem_wdata !== w) begin
                n_bad++; $display("FAIL write_beat c%0d: got %h, required %h", c, mem_wdata, w);
            end
            n_cmp++;
            if (done1 !== (c == 13) || done0 !== 1'b0 || err !== 1'b0) begin
                n_bad++; $display("FAIL write_done c%0d: got done1=%0d done0=%0d err=%0d", c, done1, done0, err);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_round_robin();
        bit   want0, want1;
        int   left0, left1, dones, beat_idx, gcount, exp_g;
        logic cur_id;
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(0); gnt_q.push_back(1);
        want0 = 1; want1 = 1; left0 = 1; left1 = 1;
        dones = 0; beat_idx = -1; gcount = 0; cur_id = 1'b0;
        for (int c = 0; c < 400 && dones < 4; c++) begin
            req_cmd0 = want0 ? 2'd2 : 2'd0; req_addr0 = 14'h010;
            req_cmd1 = want1 ? 2'd2 : 2'd0; req_addr1 = 14'h020;
            if (beat_idx >= 0) begin
                mem_rsp   = (beat_idx == 0);
                mem_rdata = 16'h2000 + 16'(gcount * 16 + beat_idx);
                rd_q.push_back({cur_id, mem_rdata});
                beat_idx  = (beat_idx == BEATS - 1) ? -1 : beat_idx + 1;
            end else begin
                mem_rsp = 1'b0; mem_rdata = '0;
            end
            @(negedge clk);
            if (gnt0 || gnt1) begin
                n_cmp++;
                exp_g = (gnt_q.size() != 0) ? gnt_q.pop_front() : -1;
                if ((gnt0 && gnt1) || int'(gnt1) != exp_g) begin
                    n_bad++; $display("FAIL rr_order: got gnt0=%0d gnt1=%0d, required R%0d", gnt0, gnt1, exp_g);
                end
                if (gnt0) want0 = 0;
                if (gnt1) want1 = 0;
                cur_id = gnt1;
                gcount++;
            end
            if (mem_cmd == 2'd2) beat_idx = 0;
            if (done0) begin
                dones++;
                if (left0 > 0) begin left0--; want0 = 1; end
            end
            if (done1) begin
                dones++;
                if (left1 > 0) begin left1--; want1 = 1; end
            end
            next_cycle();
        end
        n_cmp++;
        if (dones != 4 || gnt_q.size() != 0) begin
            n_bad++; $display("FAIL rr_complete: got %0d dones, %0d grants left; required 4 and 0", dones, gnt_q.size());
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        for (int c = 0; c <= 21; c++) begin
            req_cmd0 = (c <= 1) ? 2'd2 : 2'd0; req_addr0 = 14'h155;
            mem_rsp  = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (done0 !== (c == 19) || err !== (c == 19)) begin
                n_bad++; $display("FAIL timeout_err c%0d: got done0=%0d err=%0d, required %0d", c, done0, err, c == 19);
            end
            next_cycle();
        end
        for (int c = 0; c <= 28; c++) begin
            req_cmd0 = (c <= 1) ? 2'd2 : 2'd0; req_addr0 = 14'h156;
            mem_rsp  = (c == 18);
            if (c >= 18 && c <= 25) begin
                mem_rdata = 16'h7700 + 16'(c - 18);
                rd_q.push_back({1'b0, mem_rdata});
            end else begin
                mem_rdata = '0;
            end
            @(negedge clk);
            n_cmp++;
            if (rsp_valid0 !== (c >= 19 && c <= 26)) begin
                n_bad++; $display("FAIL late_rsp_valid c%0d: got %0d", c, rsp_valid0);
            end
            n_cmp++;
            if (done0 !== (c == 26) || err !== 1'b0) begin
                n_bad++; $display("FAIL late_rsp_done c%0d: got done0=%0d err=%0d", c, done0, err);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c <= 13; c++) begin
            req_cmd0 = (c <= 1) ? 2'd2 : 2'd0; req_addr0 = 14'h0C3;
            rst_n    = (c == 9) ? 1'b0 : 1'b1;
            mem_rsp  = (c == 6);
            if (c >= 6 && c <= 9) begin
                mem_rdata = 16'h4400 + 16'(c - 6);
                if (c <= 8) rd_q.push_back({1'b0, mem_rdata});
            end else begin
                mem_rdata = '0;
            end
            @(negedge clk);
            if (c == 10) begin
                n_cmp++;
                if (all_out !== '0) begin
                    n_bad++; $display("FAIL midreset_outputs: got %h, required 0", all_out);
                end
            end
            n_cmp++;
            if (done0 !== 1'b0 || err !== 1'b0 || rsp_valid0 !== (c >= 7 && c <= 9)) begin
                n_bad++; $display("FAIL midreset_ctrl c%0d: got done0=%0d err=%0d valid0=%0d", c, done0, err, rsp_valid0);
            end
            next_cycle();
        end
        idle_inputs();
        for (int d = 0; d <= 14; d++) begin
            req_cmd1 = (d <= 1) ? 2'd2 : 2'd0; req_addr1 = 14'h2A1;
            mem_rsp  = (d == 4);
            if (d >= 4 && d <= 11) begin
                mem_rdata = 16'h9900 + 16'(d - 4);
                rd_q.push_back({1'b1, mem_rdata});
            end else begin
                mem_rdata = '0;
            end
            @(negedge clk);
            n_cmp++;
            if (gnt1 !== (d == 1) || rsp_valid1 !== (d >= 5 && d <= 12)) begin
                n_bad++; $display("FAIL after_reset_r1 d%0d: got gnt1=%0d valid1=%0d", d, gnt1, rsp_valid1);
            end
            n_cmp++;
            if (done1 !== (d == 12) || err !== 1'b0) begin
                n_bad++; $display("FAIL after_reset_done d%0d: got done1=%0d err=%0d", d, done1, err);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_stray();
        for (int c = 0; c < 6; c++) begin
            req_cmd0  = 2'd1; req_cmd1 = 2'd1;
            mem_rsp   = 1'b1;
            mem_rdata = 16'($urandom);
            @(negedge clk);
            n_cmp++;
            if (all_out !== '0) begin
                n_bad++; $display("FAIL stray_idle c%0d: got %h, required 0", c, all_out);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_stray();
        test_read();
        test_write();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        n_cmp++;
        if (rd_q.size() != 0 || wr_q.size() != 0) begin
            n_bad++; $display("FAIL scoreboard_drain: got %0d read / %0d write left, required 0", rd_q.size(), wr_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
